// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns two raw push buttons into single-cycle up/down step
// pulses. Each button is synchronised and debounced; a press gives one pulse
// immediately, then auto-repeat pulses while the button stays held. Pressing
// both buttons locks the outputs until both are released.
module step_pulse_gen #(
    parameter int DEB_CYCLES    = 16,
    parameter int HOLD_CYCLES   = 64,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    output logic inc,
    output logic dec,
    output logic ena,
    output logic up_lvl,
    output logic dn_lvl
);

    // Debounce counter only needs to reach DEB_CYCLES-1.
    localparam int DW   = $clog2(DEB_CYCLES) + 1;
    // One timer serves both the hold delay and the repeat interval.
    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(MAXC) + 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LOAD  = TW'(REPEAT_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    // Index 0 = up button, index 1 = down button.
    logic [1:0] btn_raw;
    logic [1:0] lvl;
    logic [1:0] press;

    assign btn_raw = {btn_dn, btn_up};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          lvl_reg;
            logic          lvl_prev_reg;
            logic [DW-1:0] cnt_reg;

            // Two-flop synchroniser for the asynchronous button input.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Accept a new level only after DEB_CYCLES consecutive differing samples;
            // any sample agreeing with the current level restarts the count.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                    lvl_reg <= 1'b0;
                end else if (sync2_reg == lvl_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DEB_LAST) begin
                    lvl_reg <= sync2_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + DEB_ONE;
                end
            end

            // Previous debounced level, used to detect the 0->1 press event.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lvl_prev_reg <= 1'b0;
                end else begin
                    lvl_prev_reg <= lvl_reg;
                end
            end

            assign lvl[gi]   = lvl_reg;
            assign press[gi] = lvl_reg & ~lvl_prev_reg;
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LOCK
    } state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          dir_reg, dir_next;      // 1 = up, 0 = down; fixed for the whole press
    logic          pulse_up_next, pulse_dn_next;
    logic          inc_reg, dec_reg, ena_reg;
    logic          act_lvl, oth_lvl;

    // Level of the button that started the press, and of the other one.
    assign act_lvl = dir_reg ? lvl[0] : lvl[1];
    assign oth_lvl = dir_reg ? lvl[1] : lvl[0];

    // Next-state and pulse decode; release and the other button win over timer expiry.
    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        dir_next      = dir_reg;
        pulse_up_next = 1'b0;
        pulse_dn_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (press[0] && !press[1] && !lvl[1]) begin
                    pulse_up_next = 1'b1;
                    dir_next      = 1'b1;
                    timer_next    = HOLD_LOAD;
                    state_next    = HOLD;
                end else if (press[1] && !press[0] && !lvl[0]) begin
                    pulse_dn_next = 1'b1;
                    dir_next      = 1'b0;
                    timer_next    = HOLD_LOAD;
                    state_next    = HOLD;
                end else if (press != 2'b00) begin
                    // Simultaneous press, or press while the other is already held.
                    state_next = LOCK;
                end
            end
            HOLD, REPEAT: begin
                if (!act_lvl) begin
                    state_next = IDLE;
                end else if (oth_lvl) begin
                    state_next = LOCK;
                end else if (timer_reg == '0) begin
                    pulse_up_next = dir_reg;
                    pulse_dn_next = ~dir_reg;
                    timer_next    = REP_LOAD;
                    state_next    = REPEAT;
                end else begin
                    timer_next = timer_reg - T_ONE;
                end
            end
            LOCK: begin
                if (!lvl[0] && !lvl[1]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, timer, direction and registered step outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            dir_reg   <= 1'b0;
            inc_reg   <= 1'b0;
            dec_reg   <= 1'b0;
            ena_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            dir_reg   <= dir_next;
            inc_reg   <= pulse_up_next;
            dec_reg   <= pulse_dn_next;
            ena_reg   <= pulse_up_next | pulse_dn_next;
        end
    end

    assign inc    = inc_reg;
    assign dec    = dec_reg;
    assign ena    = ena_reg;
    assign up_lvl = lvl[0];
    assign dn_lvl = lvl[1];

endmodule
